// File: rtl/key_in.sv
// key_in: 4x4 keypad row scanner with debounce and single-key decode; define KEY_IN_REPEAT_EN for auto-repeat while held
module key_in #(
  parameter int SCAN_DIV      = 50000,
  parameter int DEB_CYCLES    = 200000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] V,
  output logic [3:0] H,
  output logic       finish,
  output logic [2:0] operator,
  output logic [3:0] key_value,
  output logic       numberflag,
  output logic       opflag
);
  localparam int CW = $clog2((SCAN_DIV > DEB_CYCLES ? SCAN_DIV : DEB_CYCLES) + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, HOLD} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_OP, K_FINISH} kind_t;
  state_t state;
  kind_t kind, kind_d;
  logic [1:0] row, col, hit_col;
  logic [3:0] pat, digit_d;
  logic [2:0] op_d;
  logic [CW-1:0] cnt;
  logic col_up, released, drop;
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b1000 >> r);
  endfunction
  // pick the lowest-index low column and decode the captured row/column into a key
  always_comb begin
    hit_col = !V[3] ? 2'd0 : !V[2] ? 2'd1 : !V[1] ? 2'd2 : 2'd3;
    kind_d  = (col == 2'd3 || (row == 2'd3 && col == 2'd0)) ? K_OP :
              (row == 2'd3 && col == 2'd2) ? K_FINISH : K_DIGIT;
    digit_d = row == 2'd3 ? 4'd0 : {2'b0, row} * 4'd3 + {2'b0, col} + 4'd1;
    op_d    = row == 2'd3 ? (col == 2'd0 ? 3'd4 : 3'd3) : {1'b0, row};
  end
  assign col_up   = V[2'd3 - col];
  assign released = col_up && cnt == DEB_LAST;
`ifdef KEY_IN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rc;
  assign drop = rc == REP_LAST && kind != K_FINISH;
  // hold-time counter driving the periodic one-cycle flag drop
  always_ff @(posedge CLK)
    if (!RESET || state != HOLD) rc <= '0;
    else rc <= rc == REP_LAST ? '0 : rc + 1'b1;
`else
  assign drop = 1'b0;
`endif
  // scan / debounce / press / hold sequencer with registered outputs
  always_ff @(posedge CLK)
    if (!RESET) begin
      state      <= SCAN;
      kind       <= K_DIGIT;
      row        <= 2'd0;
      col        <= 2'd0;
      pat        <= 4'b1111;
      cnt        <= '0;
      H          <= 4'b0111;
      key_value  <= 4'd0;
      operator   <= 3'd0;
      numberflag <= 1'b0;
      opflag     <= 1'b0;
      finish     <= 1'b0;
    end else
      case (state)
        SCAN:
          if (cnt != SCAN_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt <= '0;
            if (V == 4'b1111) begin
              row <= row + 2'd1;
              H   <= row_drive(row + 2'd1);
            end else begin
              pat   <= V;
              col   <= hit_col;
              state <= DEBOUNCE;
            end
          end
        DEBOUNCE: begin
          cnt   <= (V != pat || cnt == DEB_LAST) ? '0 : cnt + 1'b1;
          state <= V != pat ? SCAN : cnt == DEB_LAST ? PRESS : DEBOUNCE;
        end
        PRESS: begin
          kind      <= kind_d;
          key_value <= kind_d == K_DIGIT ? digit_d : key_value;
          operator  <= kind_d == K_OP ? op_d : operator;
          state     <= HOLD;
        end
        default: begin
          cnt        <= (col_up && !released) ? cnt + 1'b1 : '0;
          numberflag <= !released && !drop && kind == K_DIGIT;
          opflag     <= !released && !drop && kind == K_OP;
          finish     <= !released && kind == K_FINISH;
          if (released) begin
            state <= SCAN;
            row   <= row + 2'd1;
            H     <= row_drive(row + 2'd1);
          end
        end
      endcase
endmodule

// File: tb/tb_key_in.sv
// tb_key_in: keypad-model bench for key_in with directed and random presses
module tb_key_in;
  localparam int SD = 4, DB = 3;
  logic CLK = 0, RESET = 0;
  logic [3:0] V, H, key_value;
  logic [2:0] operator;
  logic finish, numberflag, opflag;
  logic [3:0] down [4] = '{default: 4'b0};
  int vectors = 0, miscompares = 0;
  int n_rise = 0, o_rise = 0, f_rise = 0, multi = 0, bad_h = 0;
  logic pn = 0, po = 0, pf = 0;
  logic [3:0] exp_kv = 0;
  logic [2:0] exp_op = 0;
  string keymap = "123+456-789*%0=/";
  key_in #(.SCAN_DIV(SD), .DEB_CYCLES(DB), .REPEAT_CYCLES(10)) dut (
    .CLK(CLK), .RESET(RESET), .V(V), .H(H), .finish(finish), .operator(operator),
    .key_value(key_value), .numberflag(numberflag), .opflag(opflag));
  always #5 CLK = ~CLK;
  function automatic int hrow(input logic [3:0] h);
    return !h[2] ? 1 : !h[1] ? 2 : !h[0] ? 3 : 0;
  endfunction
  function automatic logic [3:0] row_h(input int r);
    logic [3:0] one = 4'b1000;
    return ~(one >> r);
  endfunction
  assign V = ~down[hrow(H)];
  always @(posedge CLK) begin
    pn <= numberflag;
    po <= opflag;
    pf <= finish;
    if (numberflag && !pn) n_rise <= n_rise + 1;
    if (opflag && !po) o_rise <= o_rise + 1;
    if (finish && !pf) f_rise <= f_rise + 1;
    if (int'(numberflag) + int'(opflag) + int'(finish) > 1) multi <= multi + 1;
    if (RESET && $countones(~H) != 1) bad_h <= bad_h + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic wait_row(input int r);
    logic [3:0] p;
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      p = H;
      step(1);
      seen = H == row_h(r) && p != H;
    end
    check("wait_row", seen, 1);
  endtask
  task automatic finish_press(input int r, input logic [3:0] m, input int sn, input int so, input int sf);
    int c = 0, k;
    byte ch;
    bit seen = 0;
    logic [3:0] kp;
    logic [2:0] opp;
    while (c < 3 && !m[3-c]) c++;
    ch = keymap[r*4+c];
    k = (ch >= "0" && ch <= "9") ? 0 : ch == "=" ? 2 : 1;
    if (k == 0) exp_kv = 4'(ch - "0");
    if (k == 1) exp_op = 3'(ch == "+" ? 0 : ch == "-" ? 1 : ch == "*" ? 2 : ch == "/" ? 3 : 4);
    kp = key_value;
    opp = operator;
    for (int i = 0; i < 200 && !seen; i++) begin
      kp = key_value;
      opp = operator;
      step(1);
      seen = numberflag | opflag | finish;
    end
    check("rise_seen", seen, 1);
    check("numberflag", numberflag, k == 0);
    check("opflag", opflag, k == 1);
    check("finish", finish, k == 2);
    check("key_value", key_value, exp_kv);
    check("operator", operator, exp_op);
    check("kv_setup", kp, exp_kv);
    check("op_setup", opp, exp_op);
    step($urandom_range(0, 6));
    check("held", numberflag | opflag | finish, 1);
    down[r] = 4'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(1);
      seen = !(numberflag | opflag | finish);
    end
    check("fall_seen", seen, 1);
    check("next_row", H, row_h((r + 1) % 4));
    check("kv_hold", key_value, exp_kv);
    check("op_hold", operator, exp_op);
    check("n_rises", n_rise - sn, k == 0);
    check("o_rises", o_rise - so, k == 1);
    check("f_rises", f_rise - sf, k == 2);
  endtask
  task automatic press(input int r, input logic [3:0] m);
    int sn = n_rise, so = o_rise, sf = f_rise;
    down[r] = m;
    finish_press(r, m, sn, so, sf);
  endtask
  initial begin
    int sn, so, sf, r, c;
    bit seen;
    logic [3:0] m, one;
    step(2);
    check("rst_H", H, 4'b0111);
    check("rst_flags", {numberflag, opflag, finish}, 0);
    check("rst_kv", key_value, 0);
    check("rst_op", operator, 0);
    RESET = 1;
    step(SD - 1);
    check("scan_hold", H, 4'b0111);
    step(1);
    check("scan_1", H, row_h(1));
    for (int k = 2; k <= 4; k++) begin
      step(SD);
      check("scan_k", H, row_h(k % 4));
    end
    check("idle_flags", {numberflag, opflag, finish}, 0);
    down[1] = 4'b0010;
    step(SD);
    check("t2_row1", H, row_h(1));
    step(SD + DB);
    check("t2_kv_pre", key_value, 0);
    step(1);
    check("t2_kv", key_value, 6);
    check("t2_nf_lag", numberflag, 0);
    step(1);
    check("t2_nf", numberflag, 1);
    exp_kv = 6;
    down[1] = 4'b0;
    step(DB - 1);
    check("t2_nf_hold", numberflag, 1);
    step(1);
    check("t2_nf_fall", numberflag, 0);
    check("t2_row2", H, row_h(2));
    press(2, 4'b0001);
    press(3, 4'b0010);
    wait_row(0);
    sn = n_rise;
    down[0] = 4'b1000;
    step(SD + DB - 1);
    down[0] = 4'b0;
    step(20);
    check("short_nf", numberflag, 0);
    check("short_rises", n_rise - sn, 0);
    wait_row(0);
    sn = n_rise; so = o_rise; sf = f_rise;
    down[0] = 4'b1000;
    step(SD + 1);
    down[0] = 4'b0;
    step(1);
    down[0] = 4'b1000;
    finish_press(0, 4'b1000, sn, so, sf);
    press(3, 4'b1010);
    one = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      m = (one >> c) | (($urandom_range(0, 1) == 1) ? (one >> $urandom_range(c, 3)) : 4'b0);
      press(r, m);
    end
    down[1] = 4'b0100;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(1);
      seen = numberflag;
    end
    check("t6_rise", seen, 1);
    check("t6_kv", key_value, 5);
    RESET = 0;
    step(1);
    check("t6_nf", numberflag, 0);
    check("t6_kv_rst", key_value, 0);
    check("t6_op_rst", operator, 0);
    check("t6_H", H, 4'b0111);
    down[1] = 4'b0;
    RESET = 1;
    exp_kv = 0;
    exp_op = 0;
    press(1, 4'b0100);
`ifdef KEY_IN_REPEAT_EN
    sn = n_rise;
    down[1] = 4'b0100;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(1);
      seen = numberflag;
    end
    step(24);
    check("repeat_rises", n_rise - sn, 3);
    down[1] = 4'b0;
    step(10);
`endif
    check("one_flag", multi, 0);
    check("one_row", bad_h, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
